me_block_sequencer: RTL and testbench

Front-end and result stage for the 16x16 full-search motion estimator. It accepts a byte stream holding one 256-pixel reference block followed by one 1024-pixel search window and stores both in internal arrays. It then serves the estimator's combinational R/S1/S2 read ports, holds `start` for one search, and captures `bestDistance`/`motionX`/`motionY` into a valid/ready result register. It sits between the pixel DMA and the estimator top and replaces the standalone ROM_R/ROM_S models.

---
 rtl/me_block_sequencer_if.sv | 36 +++
 rtl/me_block_sequencer.sv | 71 +++++++
 tb/tb_me_block_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/me_block_sequencer_if.sv
// me_block_sequencer_if: pixel stream, estimator read/handshake and result signals
`timescale 1ns/1ps
interface me_block_sequencer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] AddressR;
   logic [9:0] AddressS1;
   logic [9:0] AddressS2;
   logic [7:0] R;
   logic [7:0] S1;
   logic [7:0] S2;
   logic       start;
   logic       completed;
   logic [7:0] bestDistance;
   logic [3:0] motionX;
   logic [3:0] motionY;
   logic       result_valid;
   logic       result_ready;
   logic [7:0] res_distance;
   logic [3:0] res_mvx;
   logic [3:0] res_mvy;
   logic [15:0] block_count;
   modport slave (
      input  in_data, in_valid, AddressR, AddressS1, AddressS2,
      input  completed, bestDistance, motionX, motionY, result_ready,
      output in_ready, R, S1, S2, start, result_valid,
      output res_distance, res_mvx, res_mvy, block_count
   );
   modport master (
      output in_data, in_valid, AddressR, AddressS1, AddressS2,
      output completed, bestDistance, motionX, motionY, result_ready,
      input  in_ready, R, S1, S2, start, result_valid,
      input  res_distance, res_mvx, res_mvy, block_count
   );
endinterface

// File: rtl/me_block_sequencer.sv
// me_block_sequencer: loads R/S pixel arrays, holds start for one search, captures the result
`timescale 1ns/1ps
module me_block_sequencer (
   input logic clock,
   input logic reset,
   me_block_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD_R, LOAD_S, RUN, SETTLE, RESULT} state_t;
   state_t      r_state, w_next;
   logic [10:0] r_wptr;
   logic [7:0]  r_rarr [256];
   logic [7:0]  r_sarr [1024];
   logic [7:0]  r_dist;
   logic [3:0]  r_mvx, r_mvy;
   logic [15:0] r_count;
   logic        w_beat, w_last_r, w_last_s, w_take;
   assign w_beat   = bus.in_valid && bus.in_ready;
   assign w_last_r = r_wptr[7:0] == 8'hFF;
   assign w_last_s = r_wptr[9:0] == 10'h3FF;
   assign w_take   = r_state == RESULT && bus.result_ready;
   always_ff @(posedge clock or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = LOAD_R;
         LOAD_R:  w_next = (w_beat && w_last_r) ? LOAD_S : LOAD_R;
         LOAD_S:  w_next = (w_beat && w_last_s) ? RUN : LOAD_S;
         RUN:     w_next = bus.completed ? SETTLE : RUN;
         SETTLE:  w_next = RESULT;
         RESULT:  w_next = bus.result_ready ? LOAD_R : RESULT;
         default: w_next = IDLE;
      endcase
   end
   // Outputs decode straight from state so reset clears them without waiting for a clock
   always_comb begin
      bus.in_ready     = r_state == LOAD_R || r_state == LOAD_S;
      bus.start        = r_state == RUN || r_state == SETTLE;
      bus.result_valid = r_state == RESULT;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) r_wptr <= '0;
      else if (w_take) r_wptr <= '0;
      else if (w_beat) r_wptr <= (r_state == LOAD_R && w_last_r) ? 11'd0 : r_wptr + 11'd1;
   always_ff @(posedge clock) begin
      if (w_beat && r_state == LOAD_R) r_rarr[r_wptr[7:0]] <= bus.in_data;
      if (w_beat && r_state == LOAD_S) r_sarr[r_wptr[9:0]] <= bus.in_data;
   end
   assign bus.R  = r_rarr[bus.AddressR];
   assign bus.S1 = r_sarr[bus.AddressS1];
   assign bus.S2 = r_sarr[bus.AddressS2];
   // The estimator's last comparator update lands with completed, so sample one cycle later
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_dist <= '0;
         r_mvx  <= '0;
         r_mvy  <= '0;
      end else if (r_state == SETTLE) begin
         r_dist <= bus.bestDistance;
         r_mvx  <= bus.motionX;
         r_mvy  <= bus.motionY;
      end
   always_ff @(posedge clock or posedge reset)
      if (reset) r_count <= '0;
      else if (w_take) r_count <= r_count + 16'd1;
   assign bus.res_distance = r_dist;
   assign bus.res_mvx      = r_mvx;
   assign bus.res_mvy      = r_mvy;
   assign bus.block_count  = r_count;
endmodule

// File: tb/tb_me_block_sequencer.sv
// tb_me_block_sequencer: random-gap loads and stub searches checked against an array model
`timescale 1ns/1ps
module tb_me_block_sequencer;
   logic clock = 0;
   logic reset = 1;
   int   total = 0;
   int   bad = 0;
   int   exp_count = 0;
   logic [7:0] ref_r [256];
   logic [7:0] ref_s [1024];
   me_block_sequencer_if bus ();
   me_block_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, want);
      end
   endtask
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset;
      #2 reset = 1;
      #1;
      chk("rst_start", bus.start, 0);
      chk("rst_rv", bus.result_valid, 0);
      chk("rst_ir", bus.in_ready, 0);
      chk("rst_cnt", bus.block_count, 0);
      chk("rst_dist", bus.res_distance, 0);
      chk("rst_mvx", bus.res_mvx, 0);
      chk("rst_mvy", bus.res_mvy, 0);
      exp_count = 0;
      tick;
      reset = 0;
      chk("rel_ir0", bus.in_ready, 0);
      tick;
      chk("rel_ir1", bus.in_ready, 1);
   endtask
   task automatic load(input bit pattern);
      logic [7:0] d [1280];
      int idx = 0;
      int cyc = 0;
      bit acc;
      for (int i = 0; i < 1280; i++) d[i] = pattern ? i[7:0] : 8'($urandom);
      for (int i = 0; i < 256; i++) ref_r[i] = d[i];
      for (int i = 0; i < 1024; i++) ref_s[i] = d[256 + i];
      while (idx < 1280 && cyc < 6000) begin
         bus.in_valid  = $urandom_range(3) != 0;
         bus.in_data   = d[idx];
         bus.completed = 1'($urandom_range(1));
         if (idx == 1279 && bus.in_valid) chk("start_pre", bus.start, 0);
         acc = bus.in_valid && bus.in_ready;
         tick;
         cyc++;
         if (acc) idx++;
      end
      chk("load_done", idx, 1280);
      bus.in_valid  = 0;
      bus.completed = 0;
      chk("start_rise", bus.start, 1);
      chk("ir_run", bus.in_ready, 0);
   endtask
   task automatic sweep;
      for (int a = 0; a < 1024; a++) begin
         bus.AddressR  = a[7:0];
         bus.AddressS1 = a[9:0];
         bus.AddressS2 = 10'(1023 - a);
         #1;
         if (a < 256) chk("rd_R", bus.R, ref_r[a]);
         chk("rd_S1", bus.S1, ref_s[a]);
         chk("rd_S2", bus.S2, ref_s[1023 - a]);
      end
      tick;
   endtask
   task automatic run_block(input int wait_n, input logic [7:0] d, input logic [3:0] mx,
                            input logic [3:0] my, input int hold);
      bus.in_valid = 1;
      bus.in_data  = 8'hA5;
      chk("run_start", bus.start, 1);
      chk("run_ir", bus.in_ready, 0);
      for (int i = 0; i < wait_n; i++) tick;
      bus.completed    = 1;
      bus.bestDistance = 8'h40;
      bus.motionX      = 4'h7;
      bus.motionY      = 4'h7;
      tick;
      chk("settle_start", bus.start, 1);
      chk("settle_rv", bus.result_valid, 0);
      bus.completed    = 0;
      bus.bestDistance = d;
      bus.motionX      = mx;
      bus.motionY      = my;
      tick;
      chk("res_rv", bus.result_valid, 1);
      chk("res_start", bus.start, 0);
      chk("res_dist", bus.res_distance, d);
      chk("res_mvx", bus.res_mvx, mx);
      chk("res_mvy", bus.res_mvy, my);
      bus.bestDistance = ~d;
      bus.motionX      = ~mx;
      bus.motionY      = ~my;
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("bp_rv", bus.result_valid, 1);
         chk("bp_dist", bus.res_distance, d);
         chk("bp_mv", {bus.res_mvx, bus.res_mvy}, {mx, my});
         chk("bp_start", bus.start, 0);
         chk("bp_ir", bus.in_ready, 0);
         chk("bp_cnt", bus.block_count, exp_count);
      end
      bus.result_ready = 1;
      tick;
      bus.result_ready = 0;
      exp_count++;
      chk("hs_rv", bus.result_valid, 0);
      chk("hs_ir", bus.in_ready, 1);
      chk("hs_cnt", bus.block_count, exp_count);
      chk("hs_keep", {bus.res_distance, bus.res_mvx, bus.res_mvy}, {d, mx, my});
      bus.in_valid = 0;
   endtask
   initial begin
      bus.in_data = 0; bus.in_valid = 0; bus.completed = 0; bus.result_ready = 0;
      bus.bestDistance = 0; bus.motionX = 0; bus.motionY = 0;
      bus.AddressR = 0; bus.AddressS1 = 0; bus.AddressS2 = 0;
      tick;
      do_reset;
      load(1);
      bus.AddressR = 8'h05; bus.AddressS1 = 10'h3FF; bus.AddressS2 = 10'h000;
      #1;
      chk("fix_R", bus.R, 8'h05);
      chk("fix_S1", bus.S1, 8'hFF);
      chk("fix_S2", bus.S2, 8'h00);
      sweep;
      run_block(20, 8'h12, 4'hD, 4'h3, 10);
      load(0);
      sweep;
      run_block($urandom_range(40, 5), 8'($urandom), 4'($urandom), 4'($urandom), $urandom_range(3));
      load(0);
      for (int i = 0; i < 5; i++) tick;
      chk("pre_rst_start", bus.start, 1);
      do_reset;
      load(0);
      sweep;
      run_block($urandom_range(40, 5), 8'($urandom), 4'($urandom), 4'($urandom), 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
